// File: rtl/usb_rst_pkg.sv
// Shared definitions for the USB reset sequencer: FSM states, register map
// and CTRL/STATUS bit positions.
package usb_rst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PULSE  = 2'd1;
  localparam logic [1:0] ADDR_SETTLE = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_FORCE  = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;
  localparam int unsigned CTRL_ABORT  = 3;

  localparam int unsigned STAT_BUSY     = 0;
  localparam int unsigned STAT_DONE     = 1;
  localparam int unsigned STAT_STATE_LO = 2;

endpackage

// File: rtl/usb_rst_sequencer_if.sv
// Avalon-MM register port of the USB reset sequencer.
interface usb_rst_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/usb_rst_timer.sv
// Loadable down-counter that parks at zero; zero flag is combinational.
module usb_rst_timer #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/usb_rst_sequencer.sv
// Software-triggered reset pulse plus settle interval for the USB host chip,
// exposed as a small Avalon-MM register slave.
module usb_rst_sequencer
  import usb_rst_pkg::*;
#(
  parameter int unsigned CNT_W          = 24,
  parameter int unsigned PULSE_DEFAULT  = 500000,
  parameter int unsigned SETTLE_DEFAULT = 2500000,
  parameter int unsigned AUTO_START     = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  usb_rst_sequencer_if.slave   bus,
  output logic                 usb_rst_n,
  output logic                 irq
);

  state_e           state_q, state_d;
  logic             force_q, force_d;
  logic             irq_en_q, irq_en_d;
  logic             done_q, done_d;
  logic             auto_pend_q, auto_pend_d;
  logic             usb_rst_n_q, usb_rst_n_d;
  logic [CNT_W-1:0] pulse_len_q, pulse_len_d;
  logic [CNT_W-1:0] settle_len_q, settle_len_d;

  logic             wr, wr_ctrl, start_req, abort_req, start_ok, done_set;
  logic             timer_load, timer_zero;
  logic [CNT_W-1:0] timer_val;
  logic             unused_wdata;

  // Zero length behaves as one cycle: load max(len,1)-1.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - CNT_W'(1);
  endfunction

  assign wr        = bus.chipselect & ~bus.write_n;
  assign wr_ctrl   = wr && (bus.address == ADDR_CTRL);
  assign abort_req = wr_ctrl && bus.writedata[CTRL_ABORT];
  assign start_req = (wr_ctrl && bus.writedata[CTRL_START]) || auto_pend_q;
  assign unused_wdata = ^bus.writedata;

  usb_rst_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    timer_val  = '0;
    start_ok   = 1'b0;
    done_set   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_req && !abort_req) begin
          state_d    = ST_ASSERT;
          timer_load = 1'b1;
          timer_val  = len_m1(pulse_len_q);
          start_ok   = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (abort_req) begin
          state_d = ST_IDLE;
        end else if (timer_zero) begin
          state_d    = ST_SETTLE;
          timer_load = 1'b1;
          timer_val  = len_m1(settle_len_q);
        end
      end
      ST_SETTLE: begin
        if (abort_req) begin
          state_d = ST_IDLE;
        end else if (timer_zero) begin
          state_d  = ST_IDLE;
          done_set = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    force_d      = wr_ctrl ? bus.writedata[CTRL_FORCE]  : force_q;
    irq_en_d     = wr_ctrl ? bus.writedata[CTRL_IRQ_EN] : irq_en_q;
    pulse_len_d  = (wr && bus.address == ADDR_PULSE)  ? bus.writedata[CNT_W-1:0] : pulse_len_q;
    settle_len_d = (wr && bus.address == ADDR_SETTLE) ? bus.writedata[CNT_W-1:0] : settle_len_q;
    auto_pend_d  = 1'b0;

    // Completion beats a same-cycle W1C; an accepted START clears DONE.
    if (done_set)
      done_d = 1'b1;
    else if (start_ok)
      done_d = 1'b0;
    else if (wr && bus.address == ADDR_STATUS && bus.writedata[STAT_DONE])
      done_d = 1'b0;
    else
      done_d = done_q;

    usb_rst_n_d = ~((state_d == ST_ASSERT) | force_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      force_q      <= 1'b0;
      irq_en_q     <= 1'b0;
      done_q       <= 1'b0;
      auto_pend_q  <= (AUTO_START != 0);
      usb_rst_n_q  <= 1'b0;
      pulse_len_q  <= CNT_W'(PULSE_DEFAULT);
      settle_len_q <= CNT_W'(SETTLE_DEFAULT);
    end else begin
      state_q      <= state_d;
      force_q      <= force_d;
      irq_en_q     <= irq_en_d;
      done_q       <= done_d;
      auto_pend_q  <= auto_pend_d;
      usb_rst_n_q  <= usb_rst_n_d;
      pulse_len_q  <= pulse_len_d;
      settle_len_q <= settle_len_d;
    end
  end

  assign usb_rst_n = usb_rst_n_q;
  assign irq       = done_q & irq_en_q;

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_CTRL: begin
        bus.readdata[CTRL_FORCE]  = force_q;
        bus.readdata[CTRL_IRQ_EN] = irq_en_q;
      end
      ADDR_PULSE:  bus.readdata[CNT_W-1:0] = pulse_len_q;
      ADDR_SETTLE: bus.readdata[CNT_W-1:0] = settle_len_q;
      default: begin
        bus.readdata[STAT_BUSY]            = (state_q != ST_IDLE);
        bus.readdata[STAT_DONE]            = done_q;
        bus.readdata[STAT_STATE_LO +: 2]   = state_q;
      end
    endcase
  end

endmodule

// File: tb/tb_usb_rst_sequencer.sv
// Scoreboard bench: a timestamp-based model of the reset sequence predicts
// readdata, usb_rst_n and irq; a monitor process compares every cycle.
module tb_usb_rst_sequencer;

  localparam int unsigned CNT_W = 8;
  localparam int PDEF = 6;
  localparam int SDEF = 5;
  localparam int BIG  = 1 << 20;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic usb_rst_n, irq;

  usb_rst_sequencer_if bus();

  usb_rst_sequencer #(
    .CNT_W(CNT_W), .PULSE_DEFAULT(PDEF), .SETTLE_DEFAULT(SDEF), .AUTO_START(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave), .usb_rst_n(usb_rst_n), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd_chk;
    logic [31:0] rd_exp;
    bit          rst_n_exp;
    bit          irq_exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  // Model: a sequence is described by its start edge t0 and lengths P, S.
  bit m_force, m_irq_en, m_done, m_active, m_auto;
  int m_pulse, m_settle;
  int e = 1;
  int t0, P, S;

  function automatic int max1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int phase(input int k);
    if (!m_active) return 0;
    if (k >= t0 && k <= t0 + P - 1) return 1;
    if (k >= t0 + P && k <= t0 + P + S - 1) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] read_model(input logic [1:0] a, input int k);
    logic [31:0] r;
    int p;
    r = '0;
    p = phase(k);
    case (a)
      2'd0: begin r[1] = m_force; r[2] = m_irq_en; end
      2'd1: r = 32'(m_pulse);
      2'd2: r = 32'(m_settle);
      default: begin r[0] = (p != 0); r[1] = m_done; r[3:2] = p[1:0]; end
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_force = 0; m_irq_en = 0; m_done = 0; m_active = 0; m_auto = 1;
    m_pulse = PDEF; m_settle = SDEF;
  endtask

  task automatic step(input bit rst, input bit cs, input bit wn,
                      input logic [1:0] a, input logic [31:0] wd, input string tag);
    exp_t x;
    int   k;
    bit   wr, wr_ctrl, busy, abort, start, start_ok, set_done;
    reset_n        = ~rst;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.address    = a;
    bus.writedata  = wd;
    if (rst) model_reset();
    k        = e - 1;
    x.rd_chk = cs && wn;
    x.rd_exp = read_model(a, k);
    x.tag    = tag;
    if (!rst) begin
      wr       = cs && !wn;
      wr_ctrl  = wr && (a == 2'd0);
      busy     = (phase(k) != 0);
      abort    = wr_ctrl && wd[3];
      start    = (wr_ctrl && wd[0]) || m_auto;
      m_auto   = 0;
      start_ok = 0;
      set_done = 0;
      if (busy) begin
        if (abort) m_active = 0;
        else if (e == t0 + P) S = max1(m_settle);
        else if (e == t0 + P + S) begin m_active = 0; set_done = 1; end
      end else if (start && !abort) begin
        m_active = 1; t0 = e; P = max1(m_pulse); S = BIG; start_ok = 1;
      end
      if (set_done) m_done = 1;
      else if (start_ok) m_done = 0;
      else if (wr && a == 2'd3 && wd[1]) m_done = 0;
      if (wr_ctrl) begin m_force = wd[1]; m_irq_en = wd[2]; end
      if (wr && a == 2'd1) m_pulse  = int'(wd[CNT_W-1:0]);
      if (wr && a == 2'd2) m_settle = int'(wd[CNT_W-1:0]);
      x.rst_n_exp = !((phase(e) == 1) || m_force);
    end else begin
      x.rst_n_exp = 1'b0;
    end
    x.irq_exp = m_done && m_irq_en;
    sb.push_back(x);
    e++;
    @(negedge clk);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d, input string tag);
    step(1'b0, 1'b1, 1'b0, a, d, tag);
  endtask

  task automatic rd_reg(input logic [1:0] a, input string tag);
    step(1'b0, 1'b1, 1'b1, a, 32'h0, tag);
  endtask

  // Pre-edge readdata is captured at the edge; outputs are checked just after it.
  logic [31:0] rd_smp;
  always @(posedge clk) rd_smp <= bus.readdata;

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        if (x.rd_chk) begin
          checks++;
          if (rd_smp !== x.rd_exp) begin
            errors++;
            $display("FAIL %s readdata got %h exp %h t=%0t", x.tag, rd_smp, x.rd_exp, $time);
          end
        end
        checks++;
        if (usb_rst_n !== x.rst_n_exp) begin
          errors++;
          $display("FAIL %s usb_rst_n got %b exp %b t=%0t", x.tag, usb_rst_n, x.rst_n_exp, $time);
        end
        checks++;
        if (irq !== x.irq_exp) begin
          errors++;
          $display("FAIL %s irq got %b exp %b t=%0t", x.tag, irq, x.irq_exp, $time);
        end
      end
    end
  end

  initial begin : driver
    int r;
    logic [31:0] d;
    model_reset();
    step(1'b1, 1'b1, 1'b1, 2'd0, 32'h0, "rst_ctrl");
    step(1'b1, 1'b1, 1'b1, 2'd1, 32'h0, "rst_pulse");
    step(1'b1, 1'b1, 1'b1, 2'd2, 32'h0, "rst_settle");
    step(1'b1, 1'b1, 1'b1, 2'd3, 32'h0, "rst_status");
    repeat (14) rd_reg(2'd3, "auto_start");

    wr_reg(2'd3, 32'h2, "w1c");
    wr_reg(2'd1, 32'd4, "pulse4");
    wr_reg(2'd2, 32'd3, "settle3");
    wr_reg(2'd0, 32'h1, "start_p4s3");
    repeat (9) rd_reg(2'd3, "seq_p4s3");

    wr_reg(2'd0, 32'h5, "start_irq");
    repeat (9) rd_reg(2'd3, "seq_irq");
    wr_reg(2'd3, 32'h2, "w1c_irq");
    repeat (2) rd_reg(2'd3, "irq_cleared");

    wr_reg(2'd1, 32'd0, "pulse0");
    wr_reg(2'd2, 32'd0, "settle0");
    wr_reg(2'd0, 32'h1, "start_zero");
    repeat (4) rd_reg(2'd3, "seq_zero");

    wr_reg(2'd1, 32'd3, "pulse3");
    wr_reg(2'd2, 32'd4, "settle4");
    wr_reg(2'd0, 32'h1, "start_p3s4");
    wr_reg(2'd1, 32'd9, "pulse9_mid");
    repeat (3) rd_reg(2'd3, "seq_p3s4");
    wr_reg(2'd0, 32'h1, "start_in_settle");
    repeat (6) rd_reg(2'd3, "seq_ignored");
    wr_reg(2'd0, 32'h1, "start_p9");
    repeat (16) rd_reg(2'd3, "seq_p9");

    wr_reg(2'd0, 32'h1, "start_abort");
    rd_reg(2'd3, "pre_abort");
    rd_reg(2'd3, "pre_abort");
    wr_reg(2'd0, 32'h8, "abort");
    repeat (3) rd_reg(2'd3, "post_abort");

    wr_reg(2'd0, 32'h2, "force");
    repeat (3) rd_reg(2'd0, "forced");
    wr_reg(2'd0, 32'h0, "unforce");
    rd_reg(2'd3, "unforced");

    wr_reg(2'd1, 32'd7, "pulse7");
    wr_reg(2'd0, 32'h1, "start_rst_mid");
    rd_reg(2'd3, "asserting");
    rd_reg(2'd3, "asserting");
    step(1'b1, 1'b0, 1'b1, 2'd0, 32'h0, "rst_mid");
    step(1'b1, 1'b0, 1'b1, 2'd0, 32'h0, "rst_mid");
    repeat (3) rd_reg(2'd1, "pulse_default");
    repeat (14) rd_reg(2'd3, "rerun");

    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 199));
      d = $urandom;
      if (r < 12) begin
        d[0] = 1'b1; d[3] = (r == 0); d[1] = ($urandom_range(0, 7) == 0);
        wr_reg(2'd0, d, "rnd_start");
      end else if (r < 18) begin
        d[0] = 1'b0; d[1] = ($urandom_range(0, 7) == 0);
        wr_reg(2'd0, d, "rnd_ctrl");
      end else if (r < 26) begin
        wr_reg(2'd1, 32'($urandom_range(0, 6)), "rnd_pulse");
      end else if (r < 34) begin
        wr_reg(2'd2, 32'($urandom_range(0, 6)), "rnd_settle");
      end else if (r < 42) begin
        wr_reg(2'd3, d, "rnd_w1c");
      end else if (r < 46) begin
        step(1'b0, 1'b0, 1'b1, 2'($urandom_range(0, 3)), d, "rnd_idle");
      end else if (r == 199) begin
        step(1'b1, 1'b1, 1'b1, 2'd3, d, "rnd_reset");
        step(1'b1, 1'b1, 1'b1, 2'd0, d, "rnd_reset");
      end else begin
        rd_reg(2'($urandom_range(0, 3)), "rnd_read");
      end
    end

    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending %0d exp 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
